// File: rtl/gray_counter_sync.sv
// Parametrised up/down counter with registered binary count and matching Gray code.
// Supports parallel load in binary or Gray, wrap or saturate at the ends, and a wrap pulse.
module gray_counter_sync #(
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic             load_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; WIDTH-1 XOR levels is the deepest path in the block.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] cnt_bin;
   logic             cnt_wrap;
   logic             at_top;
   logic             at_bot;

   always_comb begin
      load_bin = load_gray ? gray2bin(load_val) : load_val;
      at_top   = (bin_out == ALL_ONES);
      at_bot   = (bin_out == ZERO);
      cnt_bin  = bin_out;
      cnt_wrap = 1'b0;
      if (up_dn) begin
         if (!(at_top && (SATURATE != 0))) begin
            cnt_bin  = bin_out + ONE;
            cnt_wrap = at_top;
         end
      end else begin
         if (!(at_bot && (SATURATE != 0))) begin
            cnt_bin  = bin_out - ONE;
            cnt_wrap = at_bot;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_out  <= ZERO;
         gray_out <= ZERO;
         wrap     <= 1'b0;
      end else if (load) begin
         bin_out  <= load_bin;
         gray_out <= bin2gray(load_bin);
         wrap     <= 1'b0;
      end else if (en) begin
         bin_out  <= cnt_bin;
         gray_out <= bin2gray(cnt_bin);
         wrap     <= cnt_wrap;
      end else begin
         wrap     <= 1'b0;
      end
   end

endmodule

// File: doc/gray_counter_sync.md
Name: gray_counter_sync

Overview:
- Parametrised synchronous up/down counter that keeps a binary count and emits the matching Gray code, both registered and mutually consistent every cycle.
- Successor to the team's fixed 4-bit combinational binary-to-Gray converter. Adds width generalisation, sequential counting, direction control, parallel load in binary or Gray (Gray-to-binary conversion on load), wrap/saturate mode and a wrap pulse.
- Used as a Gray pointer source for clock-domain-crossing FIFOs and as a low-toggle position counter.

Parameters:
- WIDTH, 4: counter/code width in bits; legal range 2..32.
- SATURATE, 0: 0 = wrap-around at the ends of the range; 1 = hold at the end value (all ones counting up, zero counting down).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  1 = increment, 0 = decrement; sampled only when counting.
- load  input  1  parallel-load strobe.
- load_gray  input  1  1 = load_val is Gray code, 0 = load_val is binary; sampled only with load.
- load_val  input  WIDTH  value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out, i.e. bin_out ^ (bin_out >> 1).
- wrap  output  1  one-cycle pulse, registered, on a wrap-around step.

Behaviour:
- All state updates on the rising edge of clk. Priority: rst > load > en. up_dn, load_gray and load_val are ignored when not selected.
- Reset: bin_out = 0, gray_out = 0, wrap = 0 on the edge where rst = 1, regardless of the other inputs.
- Load (load = 1):
  - Binary load: bin_out <= load_val.
  - Gray load: bin_out <= Gray-to-binary(load_val), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
  - gray_out <= Gray(new bin_out) on the same edge.
  - wrap <= 0.
  - Load takes effect even if en = 1; no count step occurs in that cycle.
- Count (en = 1, load = 0):
  - Next value is bin_out ± 1 modulo 2^WIDTH.
  - gray_out is computed from the next binary value and registered on the same edge. Latency: 1 cycle from en to both outputs.
  - Consecutive gray_out values produced by counting differ in exactly one bit.
- Idle (en = 0, load = 0): bin_out and gray_out hold; wrap <= 0.
- Wrap-around, SATURATE = 0:
  - Up from all-ones goes to 0; down from 0 goes to all-ones.
  - wrap = 1 for exactly the cycle in which the wrapped value first appears on the outputs; otherwise 0.
- Saturate, SATURATE = 1:
  - Up at all-ones and down at 0 hold the value.
  - wrap stays 0 permanently.
- No combinational path from inputs to outputs. The Gray-to-binary chain is the only deep logic (WIDTH-1 XORs) and must meet timing at WIDTH = 32.
- Reset mid-count: next edge outputs zeros and any pending wrap is cleared.
- Direction change on any cycle is legal and takes effect on that cycle's step.

Test Plan:
- Reset (WIDTH=4): rst=1 with en=1, load=1, load_val=4'b1111 -> next edge bin_out=0000, gray_out=0000, wrap=0.
- Up-count 16 cycles from 0, SATURATE=0 -> gray_out runs 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. wrap=1 only on the 0000 cycle. Check at every step that gray_out == bin_out ^ (bin_out>>1) and that the Hamming distance to the previous gray_out is 1.
- Down-count from 0 -> bin_out=1111, gray_out=1000, wrap=1 for one cycle, then bin_out=1110, gray_out=1001, wrap=0.
- Loads:
  - load=1, load_gray=1, load_val=1101 -> bin_out=1001, gray_out=1101.
  - Then load_gray=0, load_val=0110 -> bin_out=0110, gray_out=0101.
  - load=1 with en=1, load_val=1111 -> bin_out=1111, wrap=0, no increment.
- SATURATE=1: load 1111, en=1, up_dn=1 for 3 cycles -> bin_out stays 1111, gray_out 1000, wrap 0. Then up_dn=0 -> bin_out=1110.
- Reset mid-operation: count up to bin_out=0111, assert rst with en=1 -> next edge all outputs 0. Deassert rst -> counting resumes 0001 one cycle later.
